// File: rtl/fc8_dma_copier.sv
// Block-transfer engine mastering the FC8 32KB RAM phy port: forward copy or constant fill.
// Assumes the RAM returns read data one cycle after the read strobe.
module fc8_dma_copier #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 15,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  fill_mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  remaining,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  mem_wr_en,
    output logic                  mem_cs_en,
    input  logic [DATA_WIDTH-1:0] mem_data_in
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fill_q, fill_d;
    logic [DATA_WIDTH-1:0] fill_val_q, fill_val_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  mem_cs_q, mem_cs_d;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        data_d     = data_q;
        fill_d     = fill_q;
        fill_val_d = fill_val_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    fill_d     = fill_mode;
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    fill_val_d = fill_value;
                    rem_d      = (len > MAX_LEN) ? MAX_LEN : len;
                    if (len == '0) begin
                        state_d = DONE;
                    end else if (fill_mode) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                state_d = abort ? IDLE : CAP;
            end
            CAP: begin
                data_d  = mem_data_in;
                state_d = abort ? IDLE : WR;
            end
            WR: begin
                // The write strobed this cycle commits on this edge even when aborting.
                src_d = src_q + 1'b1;
                dst_d = dst_q + 1'b1;
                rem_d = rem_q - 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (rem_d == '0) begin
                    state_d = DONE;
                end else if (fill_q) begin
                    state_d = WR;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        busy_d     = (state_d == RD) || (state_d == CAP) || (state_d == WR);
        done_d     = (state_d == DONE);
        mem_cs_d   = (state_d == RD) || (state_d == WR);
        mem_wr_d   = (state_d == WR);
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        if (state_d == RD) begin
            mem_addr_d = src_d;
        end else if (state_d == WR) begin
            mem_addr_d = dst_d;
            mem_data_d = fill_d ? fill_val_d : data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            fill_q     <= 1'b0;
            fill_val_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wr_q   <= 1'b0;
            mem_cs_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            fill_q     <= fill_d;
            fill_val_q <= fill_val_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wr_q   <= mem_wr_d;
            mem_cs_q   <= mem_cs_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign remaining    = rem_q;
    assign mem_addr_out = mem_addr_q;
    assign mem_data_out = mem_data_q;
    assign mem_wr_en    = mem_wr_q;
    assign mem_cs_en    = mem_cs_q;

endmodule

// File: tb/tb_fc8_dma_copier.sv
// Directed bench for fc8_dma_copier against a 1-cycle-latency RAM model.
module tb_fc8_dma_copier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        fill_mode;
    logic [14:0] src_addr;
    logic [14:0] dst_addr;
    logic [15:0] len;
    logic [7:0]  fill_value;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] remaining;
    logic [14:0] mem_addr_out;
    logic [7:0]  mem_data_out;
    logic        mem_wr_en;
    logic        mem_cs_en;
    logic [7:0]  mem_data_in;

    logic [7:0]  ram [0:32767];
    logic        tb_wr_en;
    logic [14:0] tb_wr_addr;
    logic [7:0]  tb_wr_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int cs_count     = 0;
    int wr_count     = 0;

    fc8_dma_copier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .fill_mode    (fill_mode),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .fill_value   (fill_value),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .remaining    (remaining),
        .mem_addr_out (mem_addr_out),
        .mem_data_out (mem_data_out),
        .mem_wr_en    (mem_wr_en),
        .mem_cs_en    (mem_cs_en),
        .mem_data_in  (mem_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read data, bench preload port has priority.
    always @(posedge clk) begin
        if (tb_wr_en) begin
            ram[tb_wr_addr] <= tb_wr_data;
        end else if (mem_cs_en) begin
            if (mem_wr_en) ram[mem_addr_out] <= mem_data_out;
            else           mem_data_in <= ram[mem_addr_out];
        end
    end

    always @(posedge clk) begin
        if (mem_cs_en) cs_count <= cs_count + 1;
        if (mem_cs_en && mem_wr_en) wr_count <= wr_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [14:0] addr, input logic [7:0] data);
        tb_wr_en   = 1'b1;
        tb_wr_addr = addr;
        tb_wr_data = data;
        @(posedge clk); #1;
        tb_wr_en   = 1'b0;
    endtask

    // Pulses start for one edge; returns at the sample point of cycle 1.
    task automatic applyStimulus(input logic fm, input logic [14:0] src, input logic [14:0] dst,
                                 input logic [15:0] n, input logic [7:0] fv);
        start      = 1'b1;
        fill_mode  = fm;
        src_addr   = src;
        dst_addr   = dst;
        len        = n;
        fill_value = fv;
        @(posedge clk); #1;
        start      = 1'b0;
        fill_mode  = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        len        = '0;
        fill_value = '0;
    endtask

    // Starting at cycle 1, advance until done is seen; done_cycle stays 0 on timeout.
    task automatic waitDone(input int max_cycles, output int done_cycle, output int busy_cycles);
        done_cycle  = 0;
        busy_cycles = 0;
        for (int c = 1; c <= max_cycles; c++) begin
            if (done) begin
                done_cycle = c;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int done_cycle;
        int busy_cycles;
        int cs_base;
        int wr_base;
        int wr_seen;
        int done_seen;
        logic [7:0] copy_data [4];
        copy_data[0] = 8'h11;
        copy_data[1] = 8'h22;
        copy_data[2] = 8'h33;
        copy_data[3] = 8'h44;

        rst_n = 1'b0; start = 1'b0; fill_mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_value = '0; abort = 1'b0; tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy",      32'(busy), 32'h0);
        checkOutput("reset done",      32'(done), 32'h0);
        checkOutput("reset remaining", 32'(remaining), 32'h0);
        checkOutput("reset addr",      32'(mem_addr_out), 32'h0);
        checkOutput("reset cs",        32'(mem_cs_en), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Copy 4 bytes
        for (int i = 0; i < 4; i++) begin
            preload(15'h0100 + 15'(i), copy_data[i]);
            preload(15'h2000 + 15'(i), 8'hEE);
        end
        applyStimulus(1'b0, 15'h0100, 15'h2000, 16'd4, 8'h00);
        checkOutput("copy remaining c1", 32'(remaining), 32'd4);
        checkOutput("copy rd addr c1",   32'(mem_addr_out), 32'h0100);
        waitDone(40, done_cycle, busy_cycles);
        checkOutput("copy done cycle",  32'(done_cycle), 32'd13);
        checkOutput("copy busy cycles", 32'(busy_cycles), 32'd12);
        checkOutput("copy busy at done", 32'(busy), 32'h0);
        @(posedge clk); #1;
        checkOutput("copy done single", 32'(done), 32'h0);
        for (int i = 0; i < 4; i++)
            checkOutput("copy dst byte", 32'(ram[15'h2000 + 15'(i)]), 32'(copy_data[i]));

        // Fill with address wrap
        preload(15'h7FFE, 8'h00);
        preload(15'h7FFF, 8'h00);
        preload(15'h0000, 8'h00);
        preload(15'h0001, 8'h3C);
        applyStimulus(1'b1, 15'h0000, 15'h7FFE, 16'd3, 8'hA5);
        checkOutput("fill data c1", 32'(mem_data_out), 32'hA5);
        checkOutput("fill wr c1",   32'(mem_wr_en), 32'h1);
        waitDone(20, done_cycle, busy_cycles);
        checkOutput("fill done cycle", 32'(done_cycle), 32'd4);
        checkOutput("fill 7FFE", 32'(ram[15'h7FFE]), 32'hA5);
        checkOutput("fill 7FFF", 32'(ram[15'h7FFF]), 32'hA5);
        checkOutput("fill 0000", 32'(ram[15'h0000]), 32'hA5);
        checkOutput("fill 0001 kept", 32'(ram[15'h0001]), 32'h3C);

        // Zero length
        @(posedge clk); #1;
        cs_base = cs_count;
        applyStimulus(1'b0, 15'h0100, 15'h2000, 16'd0, 8'h00);
        waitDone(5, done_cycle, busy_cycles);
        checkOutput("len0 done cycle", 32'(done_cycle), 32'd1);
        checkOutput("len0 remaining",  32'(remaining), 32'h0);
        checkOutput("len0 no cs",      32'(cs_count - cs_base), 32'h0);

        // Oversized length clamps to 32K; abort in first WR commits one byte
        @(posedge clk); #1;
        preload(15'h5000, 8'h00);
        preload(15'h5001, 8'h00);
        applyStimulus(1'b1, 15'h0000, 15'h5000, 16'hFFFF, 8'h99);
        checkOutput("clamp remaining", 32'(remaining), 32'h8000);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("clamp abort remaining", 32'(remaining), 32'h7FFF);
        checkOutput("clamp abort busy",      32'(busy), 32'h0);
        checkOutput("clamp 5000 written",    32'(ram[15'h5000]), 32'h99);
        checkOutput("clamp 5001 kept",       32'(ram[15'h5001]), 32'h00);

        // Abort a 10-byte copy during its third WR cycle
        for (int i = 0; i < 4; i++) begin
            preload(15'h0400 + 15'(i), 8'hA0 + 8'(i));
            preload(15'h0500 + 15'(i), 8'hFF);
        end
        wr_base = wr_count;
        applyStimulus(1'b0, 15'h0400, 15'h0500, 16'd10, 8'h00);
        wr_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            if (mem_wr_en) wr_seen++;
            if (wr_seen == 3) break;
            @(posedge clk); #1;
        end
        checkOutput("abort reached 3rd WR", 32'(wr_seen), 32'd3);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort busy",      32'(busy), 32'h0);
        checkOutput("abort cs",        32'(mem_cs_en), 32'h0);
        checkOutput("abort remaining", 32'(remaining), 32'd7);
        checkOutput("abort writes",    32'(wr_count - wr_base), 32'd3);
        checkOutput("abort byte 2",    32'(ram[15'h0502]), 32'hA2);
        checkOutput("abort byte 3",    32'(ram[15'h0503]), 32'hFF);
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) done_seen++;
            @(posedge clk); #1;
        end
        checkOutput("abort no done", 32'(done_seen), 32'h0);
        applyStimulus(1'b1, 15'h0000, 15'h0600, 16'd2, 8'h5C);
        waitDone(10, done_cycle, busy_cycles);
        checkOutput("restart done cycle", 32'(done_cycle), 32'd3);

        // Forward-overlapping copy replicates the first byte
        preload(15'h0010, 8'h5A);
        for (int i = 1; i <= 4; i++) preload(15'h0010 + 15'(i), 8'h00 + 8'(i));
        applyStimulus(1'b0, 15'h0010, 15'h0011, 16'd4, 8'h00);
        waitDone(40, done_cycle, busy_cycles);
        checkOutput("overlap done cycle", 32'(done_cycle), 32'd13);
        for (int i = 1; i <= 4; i++)
            checkOutput("overlap byte", 32'(ram[15'h0010 + 15'(i)]), 32'h5A);

        // Reset in the middle of a fill, with an ignored start beforehand
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) preload(15'h3000 + 15'(i), 8'h00);
        preload(15'h0700, 8'h00);
        wr_base = wr_count;
        applyStimulus(1'b1, 15'h0000, 15'h3000, 16'd20, 8'h77);
        @(posedge clk); #1;
        start = 1'b1; fill_mode = 1'b1; dst_addr = 15'h0700; len = 16'd1; fill_value = 8'h11;
        @(posedge clk); #1;
        start = 1'b0; fill_mode = 1'b0; dst_addr = '0; len = '0; fill_value = '0;
        checkOutput("ignored start remaining", 32'(remaining), 32'd18);
        checkOutput("ignored start addr",      32'(mem_addr_out), 32'h3002);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy",      32'(busy), 32'h0);
        checkOutput("midreset cs",        32'(mem_cs_en), 32'h0);
        checkOutput("midreset wr",        32'(mem_wr_en), 32'h0);
        checkOutput("midreset remaining", 32'(remaining), 32'h0);
        checkOutput("midreset addr",      32'(mem_addr_out), 32'h0);
        checkOutput("midreset data",      32'(mem_data_out), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset writes",  32'(wr_count - wr_base), 32'd2);
        checkOutput("midreset 3001",    32'(ram[15'h3001]), 32'h77);
        checkOutput("midreset 3002",    32'(ram[15'h3002]), 32'h00);
        checkOutput("midreset 0700",    32'(ram[15'h0700]), 32'h00);
        checkOutput("midreset idle busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
